// File: rtl/dma_ahb32_defines.sv
// Shared register map, STATUS layout and AHB-Lite encodings for the DMA peripheral FIFO.
package dma_ahb32_defines;

  localparam logic [3:0] ADDR_TXDATA = 4'h0;
  localparam logic [3:0] ADDR_RXDATA = 4'h4;
  localparam logic [3:0] ADDR_STATUS = 4'h8;

  localparam int unsigned STAT_TX_LSB  = 0;
  localparam int unsigned STAT_RX_LSB  = 16;
  localparam int unsigned STAT_LEVEL_W = 8;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HSIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ERR1 = 2'd1,
    ST_ERR2 = 2'd2
  } ahb_state_t;

  function automatic logic [31:0] status_word(input logic [7:0] rx_level,
                                              input logic [7:0] tx_level);
    logic [31:0] w;
    w = '0;
    w[STAT_RX_LSB +: STAT_LEVEL_W] = rx_level;
    w[STAT_TX_LSB +: STAT_LEVEL_W] = tx_level;
    return w;
  endfunction

endpackage

// File: rtl/dma_ahb32_sync_fifo.sv
// Single-clock FIFO; storage is not reset, only pointers, level and flags.
module dma_ahb32_sync_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 32,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned LW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [LW-1:0]    level,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;
  logic [LW-1:0]    level_d;

  // A push into a full FIFO is only legal when a pop frees the slot in the same cycle.
  assign do_push = push & (~full | pop);
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  always_comb begin
    level_d = level;
    if (do_push && !do_pop)      level_d = level + LW'(1);
    else if (!do_push && do_pop) level_d = level - LW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      level <= level_d;
      full  <= (level_d == LW'(DEPTH));
      empty <= (level_d == LW'(0));
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/dma_ahb32_periph_fifo.sv
// AHB-Lite slave front-end for a TX/RX word FIFO pair with DMA request handshakes.
module dma_ahb32_periph_fifo
  import dma_ahb32_defines::*;
#(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned TX_THRESH = 4,
  parameter int unsigned RX_THRESH = 4
) (
  input  logic        hclk,
  input  logic        hresetn,
  input  logic        hsel,
  input  logic [3:0]  haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [1:0]  hsize,
  input  logic [31:0] hwdata,
  input  logic        hready,
  output logic        hreadyout,
  output logic        hresp,
  output logic [31:0] hrdata,
  output logic        tx_req,
  input  logic        tx_clr,
  output logic        rx_req,
  input  logic        rx_clr,
  output logic        tx_valid,
  output logic [31:0] tx_data,
  input  logic        tx_ready,
  input  logic        rx_valid,
  input  logic [31:0] rx_data,
  output logic        rx_ready
);

  localparam int unsigned LW = $clog2(DEPTH) + 1;

  ahb_state_t    state, state_d;
  logic          hreadyout_d, hresp_d;
  logic [31:0]   hrdata_d;
  logic          wr_pend, wr_pend_d;
  logic          rx_pop;
  logic          accept, bad;
  logic          tx_hold, rx_hold;

  logic [LW-1:0] tx_level, rx_level, tx_free;
  logic          tx_full, tx_empty, rx_full, rx_empty;
  logic          tx_full_eff;
  logic [31:0]   rx_head;

  dma_ahb32_sync_fifo #(.DEPTH(DEPTH), .WIDTH(32)) u_tx_fifo (
    .clk   (hclk),
    .rst_n (hresetn),
    .push  (wr_pend),
    .wdata (hwdata),
    .pop   (tx_ready & ~tx_empty),
    .rdata (tx_data),
    .level (tx_level),
    .full  (tx_full),
    .empty (tx_empty)
  );

  dma_ahb32_sync_fifo #(.DEPTH(DEPTH), .WIDTH(32)) u_rx_fifo (
    .clk   (hclk),
    .rst_n (hresetn),
    .push  (rx_valid & ~rx_full),
    .wdata (rx_data),
    .pop   (rx_pop),
    .rdata (rx_head),
    .level (rx_level),
    .full  (rx_full),
    .empty (rx_empty)
  );

  assign tx_valid = ~tx_empty;
  assign rx_ready = ~rx_full;
  assign tx_free  = LW'(DEPTH) - tx_level;
  assign accept   = hsel & hready & (htrans != HTRANS_IDLE) & (htrans != HTRANS_BUSY);

  // A write still in its data phase will land before this one, so count it as occupied.
  assign tx_full_eff = tx_full | (wr_pend & (tx_level == LW'(DEPTH - 1)));

  always_comb begin
    bad = 1'b0;
    if (hsize != HSIZE_WORD || haddr[1:0] != 2'b00) bad = 1'b1;
    else if (hwrite)                                bad = (haddr != ADDR_TXDATA) | tx_full_eff;
    else if (haddr == ADDR_RXDATA)                  bad = rx_empty;
    else                                            bad = (haddr != ADDR_STATUS);
  end

  // Reads capture their data at the address edge, so RX pops there and hrdata is registered.
  always_comb begin
    state_d     = state;
    hreadyout_d = 1'b1;
    hresp_d     = 1'b0;
    hrdata_d    = '0;
    wr_pend_d   = 1'b0;
    rx_pop      = 1'b0;
    case (state)
      ST_ERR1: begin
        state_d = ST_ERR2;
        hresp_d = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
        if (accept) begin
          if (bad) begin
            state_d     = ST_ERR1;
            hreadyout_d = 1'b0;
            hresp_d     = 1'b1;
          end else if (hwrite) begin
            wr_pend_d = 1'b1;
          end else if (haddr == ADDR_RXDATA) begin
            rx_pop   = 1'b1;
            hrdata_d = rx_head;
          end else begin
            hrdata_d = status_word(8'(rx_level), 8'(tx_level));
          end
        end
      end
    endcase
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state     <= ST_IDLE;
      hreadyout <= 1'b1;
      hresp     <= 1'b0;
      hrdata    <= '0;
      wr_pend   <= 1'b0;
    end else begin
      state     <= state_d;
      hreadyout <= hreadyout_d;
      hresp     <= hresp_d;
      hrdata    <= hrdata_d;
      wr_pend   <= wr_pend_d;
    end
  end

  // A clr pulse masks the request for its own cycle and, via the hold, the following one.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      tx_req  <= 1'b0;
      rx_req  <= 1'b0;
      tx_hold <= 1'b0;
      rx_hold <= 1'b0;
    end else begin
      tx_hold <= tx_clr;
      rx_hold <= rx_clr;
      tx_req  <= (tx_free >= LW'(TX_THRESH)) & ~tx_clr & ~tx_hold;
      rx_req  <= (rx_level >= LW'(RX_THRESH)) & ~rx_clr & ~rx_hold;
    end
  end

endmodule

// File: tb/tb_dma_ahb32_periph_fifo.sv
// Directed, table-driven bench for dma_ahb32_periph_fifo with DEPTH=8 and thresholds of 4.
module tb_dma_ahb32_periph_fifo;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic        hsel;
  logic [3:0]  haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [1:0]  hsize;
  logic [31:0] hwdata;
  logic        hready;
  logic        hreadyout;
  logic        hresp;
  logic [31:0] hrdata;
  logic        tx_req, tx_clr, rx_req, rx_clr;
  logic        tx_valid, tx_ready, rx_valid, rx_ready;
  logic [31:0] tx_data, rx_data;

  int n_checks = 0;
  int n_fail   = 0;

  dma_ahb32_periph_fifo #(.DEPTH(8), .TX_THRESH(4), .RX_THRESH(4)) dut (
    .hclk      (hclk),
    .hresetn   (hresetn),
    .hsel      (hsel),
    .haddr     (haddr),
    .htrans    (htrans),
    .hwrite    (hwrite),
    .hsize     (hsize),
    .hwdata    (hwdata),
    .hready    (hready),
    .hreadyout (hreadyout),
    .hresp     (hresp),
    .hrdata    (hrdata),
    .tx_req    (tx_req),
    .tx_clr    (tx_clr),
    .rx_req    (rx_req),
    .rx_clr    (rx_clr),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready)
  );

  always #5 hclk = ~hclk;
  assign hready = hreadyout;

  typedef struct {
    logic        wr;
    logic [3:0]  addr;
    logic [1:0]  size;
    logic [31:0] wdata;
    logic        exp_err;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic        exp_txreq;
  } vec_t;

  vec_t tbl1[17];
  vec_t tbl2[6];

  function automatic vec_t mk(input logic wr, input logic [3:0] addr, input logic [1:0] size,
                              input logic [31:0] wdata, input logic exp_err, input logic chk_rd,
                              input logic [31:0] exp_rd, input logic exp_txreq);
    vec_t v;
    v.wr = wr; v.addr = addr; v.size = size; v.wdata = wdata;
    v.exp_err = exp_err; v.chk_rd = chk_rd; v.exp_rd = exp_rd; v.exp_txreq = exp_txreq;
    return v;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Entered and left at 1ns after a rising edge; one non-pipelined transfer.
  task automatic ahb_xfer(input logic wr, input logic [3:0] addr, input logic [1:0] size,
                          input logic [31:0] wdata, output logic err, output logic [31:0] rdata,
                          output logic proto_ok);
    hsel = 1'b1; htrans = 2'b10; hwrite = wr; haddr = addr; hsize = size;
    @(posedge hclk); #1;
    hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hwdata = wdata;
    @(negedge hclk);
    rdata = hrdata;
    if (hreadyout) begin
      err = hresp;
      proto_ok = 1'b1;
    end else begin
      proto_ok = hresp;
      @(negedge hclk);
      err = 1'b1;
      proto_ok = proto_ok & hreadyout & hresp;
    end
    @(posedge hclk); #1;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    logic e, p;
    logic [31:0] rd;
    ahb_xfer(v.wr, v.addr, v.size, v.wdata, e, rd, p);
    check32({tag, " resp"}, 32'(e), 32'(v.exp_err));
    check32({tag, " protocol"}, 32'(p), 32'd1);
    if (v.chk_rd) check32({tag, " rdata"}, rd, v.exp_rd);
    @(posedge hclk); @(negedge hclk);
    check32({tag, " tx_req"}, 32'(tx_req), 32'(v.exp_txreq));
    @(posedge hclk); #1;
  endtask

  initial begin
    #100000;
    n_fail++;
    $display("FAIL watchdog: time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    logic e, p;
    logic [31:0] rd;

    tbl1[0]  = mk(1'b1, 4'h0, 2'b00, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
    tbl1[1]  = mk(1'b0, 4'h8, 2'b10, 32'h0, 1'b0, 1'b1, 32'h0, 1'b1);
    for (int k = 1; k <= 8; k++)
      tbl1[1+k] = mk(1'b1, 4'h0, 2'b10, 32'h1000_0000 + 32'(k), 1'b0, 1'b0, 32'h0, (k <= 4));
    tbl1[10] = mk(1'b1, 4'h0, 2'b10, 32'h1000_0009, 1'b1, 1'b0, 32'h0, 1'b0);
    tbl1[11] = mk(1'b0, 4'h8, 2'b10, 32'h0, 1'b0, 1'b1, 32'h0000_0008, 1'b0);
    tbl1[12] = mk(1'b0, 4'h4, 2'b10, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    tbl1[13] = mk(1'b0, 4'h0, 2'b10, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    tbl1[14] = mk(1'b1, 4'h4, 2'b10, 32'h1234, 1'b1, 1'b0, 32'h0, 1'b0);
    tbl1[15] = mk(1'b1, 4'h8, 2'b10, 32'h1234, 1'b1, 1'b0, 32'h0, 1'b0);
    tbl1[16] = mk(1'b0, 4'hC, 2'b10, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);

    tbl2[0] = mk(1'b0, 4'h8, 2'b10, 32'h0, 1'b0, 1'b1, 32'h0004_0000, 1'b1);
    for (int k = 1; k <= 4; k++)
      tbl2[k] = mk(1'b0, 4'h4, 2'b10, 32'h0, 1'b0, 1'b1, 32'hA5A5_0000 + 32'(k), 1'b1);
    tbl2[5] = mk(1'b0, 4'h4, 2'b10, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);

    hresetn = 1'b0; hsel = 1'b0; haddr = '0; htrans = 2'b00; hwrite = 1'b0; hsize = 2'b10;
    hwdata = '0; tx_clr = 1'b0; rx_clr = 1'b0; tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;

    // Reset values
    repeat (3) @(posedge hclk);
    #1;
    check32("rst hreadyout", 32'(hreadyout), 32'd1);
    check32("rst hresp", 32'(hresp), 32'd0);
    check32("rst hrdata", hrdata, 32'h0);
    check32("rst tx_valid", 32'(tx_valid), 32'd0);
    check32("rst tx_req", 32'(tx_req), 32'd0);
    check32("rst rx_req", 32'(rx_req), 32'd0);
    hresetn = 1'b1;
    @(negedge hclk);
    check32("rst rx_ready", 32'(rx_ready), 32'd1);
    @(posedge hclk); @(negedge hclk);
    check32("post-rst tx_req", 32'(tx_req), 32'd1);
    @(posedge hclk); #1;

    // Fill TX, overflow, illegal accesses
    for (int i = 0; i < 17; i++) run_vec(tbl1[i], $sformatf("t1v%0d", i));
    check32("tx head", tx_data, 32'h1000_0001);

    // Full TX: stream pop and AHB write in the same cycle -> write still errors
    hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 4'h0; hsize = 2'b10; tx_ready = 1'b1;
    @(negedge hclk);
    check32("popfull tx_data", tx_data, 32'h1000_0001);
    @(posedge hclk); #1;
    tx_ready = 1'b0; hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hwdata = 32'hDEAD_BEEF;
    @(negedge hclk);
    check32("popfull err1", {30'd0, hreadyout, hresp}, 32'b01);
    @(negedge hclk);
    check32("popfull err2", {30'd0, hreadyout, hresp}, 32'b11);
    @(posedge hclk); #1;
    ahb_xfer(1'b0, 4'h8, 2'b10, 32'h0, e, rd, p);
    check32("popfull status", rd, 32'h0000_0007);
    check32("popfull new head", tx_data, 32'h1000_0002);

    // Drain TX in order
    tx_ready = 1'b1;
    for (int k = 2; k <= 8; k++) begin
      @(negedge hclk);
      check32($sformatf("drain %0d", k), tx_data, 32'h1000_0000 + 32'(k));
      @(posedge hclk); #1;
    end
    tx_ready = 1'b0;
    @(negedge hclk);
    check32("drained tx_valid", 32'(tx_valid), 32'd0);
    @(posedge hclk); @(negedge hclk);
    check32("drained tx_req", 32'(tx_req), 32'd1);

    // tx_clr pulse: low for two cycles, then back
    @(posedge hclk); #1;
    tx_clr = 1'b1;
    @(negedge hclk);
    check32("clr same cycle", 32'(tx_req), 32'd1);
    @(posedge hclk); #1;
    tx_clr = 1'b0;
    @(negedge hclk);
    check32("clr +1", 32'(tx_req), 32'd0);
    @(posedge hclk); @(negedge hclk);
    check32("clr +2", 32'(tx_req), 32'd0);
    @(posedge hclk); @(negedge hclk);
    check32("clr +3", 32'(tx_req), 32'd1);
    @(posedge hclk); #1;

    // RX stream fill, rx_req, ordered reads
    rx_valid = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      rx_data = 32'hA5A5_0000 + 32'(k);
      @(negedge hclk);
      check32($sformatf("rx_ready %0d", k), 32'(rx_ready), 32'd1);
      @(posedge hclk); #1;
    end
    rx_valid = 1'b0;
    @(negedge hclk);
    check32("rx_req before", 32'(rx_req), 32'd0);
    @(posedge hclk); @(negedge hclk);
    check32("rx_req after", 32'(rx_req), 32'd1);
    @(posedge hclk); #1;
    for (int i = 0; i < 6; i++) run_vec(tbl2[i], $sformatf("t2v%0d", i));
    check32("rx_req drained", 32'(rx_req), 32'd0);

    // RX overflow from the stream side is refused
    rx_valid = 1'b1;
    for (int k = 0; k < 9; k++) begin
      rx_data = 32'hB000_0000 + 32'(k);
      @(posedge hclk); #1;
    end
    rx_valid = 1'b0;
    @(negedge hclk);
    check32("rx full ready", 32'(rx_ready), 32'd0);
    @(posedge hclk); #1;
    ahb_xfer(1'b0, 4'h8, 2'b10, 32'h0, e, rd, p);
    check32("rx full status", rd, 32'h0008_0000);
    ahb_xfer(1'b0, 4'h4, 2'b10, 32'h0, e, rd, p);
    check32("rx full first", rd, 32'hB000_0000);

    // Reset in the middle of an ERROR response
    ahb_xfer(1'b1, 4'h0, 2'b10, 32'h1000_0009, e, rd, p);
    check32("pre-rst write", 32'(e), 32'd0);
    @(negedge hclk);
    check32("pre-rst rx_req", 32'(rx_req), 32'd1);
    @(posedge hclk); #1;
    hsel = 1'b1; htrans = 2'b10; hwrite = 1'b0; haddr = 4'h0; hsize = 2'b10;
    @(posedge hclk); #1;
    hsel = 1'b0; htrans = 2'b00;
    @(negedge hclk);
    check32("mid-err hreadyout", 32'(hreadyout), 32'd0);
    hresetn = 1'b0;
    #1;
    check32("abort hready/resp", {30'd0, hreadyout, hresp}, 32'b10);
    check32("abort tx_valid", 32'(tx_valid), 32'd0);
    check32("abort rx_ready", 32'(rx_ready), 32'd1);
    check32("abort reqs", {30'd0, tx_req, rx_req}, 32'b00);
    @(posedge hclk); #1;
    hresetn = 1'b1;
    @(posedge hclk); #1;
    ahb_xfer(1'b0, 4'h8, 2'b10, 32'h0, e, rd, p);
    check32("post-abort status", rd, 32'h0);
    check32("post-abort resp", 32'(e), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dma_ahb32_periph_fifo.md
DMA_AHB32_PERIPH_FIFO -- requirements
Module: dma_ahb32_periph_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 8, FIFO depth in 32-bit words (power of 2, 2..64).
REQ-002 SHALL have parameter TX_THRESH, default 4, free words needed to raise tx_req (1..DEPTH).
REQ-003 SHALL have parameter RX_THRESH, default 4, filled words needed to raise rx_req (1..DEPTH).
REQ-004 SHALL have ports: hclk in 1, single clock; all logic on rising edge.
REQ-005 SHALL have ports: hresetn in 1, reset; one clock; reset is asynchronous and active-low.
REQ-006 SHALL have AHB-Lite slave ports: hsel in 1; haddr in 4 (byte offset); htrans in 2; hwrite in 1; hsize in 2; hwdata in 32; hready in 1; hreadyout out 1; hresp out 1 (1=ERROR); hrdata out 32.
REQ-007 SHALL have DMA handshake ports: tx_req out 1; tx_clr in 1; rx_req out 1; rx_clr in 1.
REQ-008 SHALL have stream ports: tx_valid out 1; tx_data out 32; tx_ready in 1 (consumer); rx_valid in 1; rx_data in 32; rx_ready out 1 (producer).

Function
REQ-009 SHALL accept an address phase when hsel & htrans[1] & hready; IDLE/BUSY SHALL get zero-wait OKAY.
REQ-010 SHALL map: 0x0 TXDATA write-only; 0x4 RXDATA read-only; 0x8 STATUS read-only {rx_level[23:16], tx_level[7:0]}, other bits 0.
REQ-011 SHALL push hwdata into TX FIFO in the data phase of an OKAY write to 0x0; zero wait states.
REQ-012 SHALL drive hrdata from RX FIFO head in the data phase of a read to 0x4 and pop it in that cycle; zero wait states.
REQ-013 SHALL return a two-cycle ERROR (cycle 1 hreadyout=0 hresp=1; cycle 2 hreadyout=1 hresp=1) for: hsize!=2'b10, write TX when full, read RX when empty, write to 0x4/0x8, read 0x0, offset 0xC; no FIFO change.
REQ-014 SHALL decide full/empty errors from levels at address phase, counting any same-cycle stream pop/push of prior cycles only.
REQ-015 SHALL present TX FIFO head on tx_data with tx_valid=!tx_empty; pop when tx_valid & tx_ready.
REQ-016 SHALL drive rx_ready=!rx_full; push rx_data when rx_valid & rx_ready.
REQ-017 SHALL handle simultaneous push and pop on one FIFO: level unchanged; allowed when full (TX) only if pop occurs, i.e. full FIFO with pop and AHB write still errors per REQ-014.
REQ-018 SHALL keep levels 0..DEPTH with log2(DEPTH)+1-bit counters; pointers wrap modulo DEPTH.
REQ-019 SHALL register tx_req = (tx_free >= TX_THRESH) & !tx_clr & !tx_hold, where tx_hold is tx_clr delayed one cycle; rx_req likewise with rx_level >= RX_THRESH.
REQ-020 SHALL therefore drop req the cycle after clr and keep it low at least two cycles, then re-evaluate.
REQ-021 SHALL ignore clr while req is low (no state change beyond the hold).
REQ-022 SHALL treat an ERROR's first cycle as a pending data phase; a new address phase is not accepted while hreadyout=0.

Reset
REQ-023 SHALL on hresetn low: FIFOs empty, pointers 0, tx_req=0, rx_req=0, hreadyout=1, hresp=0, hrdata=0, tx_valid=0, rx_ready=1 (after release), error state cleared.
REQ-024 SHALL abort any in-flight AHB data phase on reset; no partial push/pop.
REQ-025 SHALL NOT clear FIFO storage contents (only pointers).

Structure
REQ-026 SHALL put address offsets, STATUS bit positions and HTRANS/HSIZE encodings in shared package dma_ahb32_defines.
REQ-027 SHALL instantiate sub-module dma_ahb32_sync_fifo (parameterised DEPTH, push/pop/level/full/empty) twice, TX and RX.
REQ-028 SHALL implement the AHB slave as a 3-state FSM: IDLE, ERR1, ERR2.

Verification
REQ-029 SHALL test: after reset, write 0x0 eight times -> tx_level 8, tx_req falls when free<4; 9th write -> ERROR two cycles, level stays 8.
REQ-030 SHALL test: rx_valid=1 with 0xA5A5_0001..0xA5A5_0004 -> rx_req=1 next cycle; four reads of 0x4 return data in order, OKAY.
REQ-031 SHALL test: tx_req=1, pulse tx_clr one cycle -> tx_req 0 for two cycles, then 1 again if free>=4.
REQ-032 SHALL test: TX full, tx_ready=1 and AHB write same cycle -> pop occurs, write errors, level 7.
REQ-033 SHALL test: hsize=2'b00 write to 0x0 -> ERROR, no push; read 0x8 -> STATUS matches levels.
REQ-034 SHALL test: hresetn low mid ERR1 -> hreadyout=1, hresp=0, levels 0 immediately.
